// File: rtl/dbg_bridge_pkg.sv
// Shared constants and state encoding for the UART debug-to-memory-bus bridge.
package dbg_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    localparam logic [7:0] RSP_ACK  = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_BUS,
        ST_RESP
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/dbg_bus_bridge_if.sv
// Byte-stream, arbiter and valid/ready memory-bus signals of the debug bridge.
interface dbg_bus_bridge_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    logic        bus_req;
    logic        bus_gnt;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        busy;

    // Bridge side.
    modport master (
        input  rx_valid, rx_data, tx_ready, bus_gnt, mem_ready, mem_rdata,
        output rx_ready, tx_valid, tx_data, bus_req, mem_valid,
               mem_addr, mem_wdata, mem_wstrb, busy
    );

    // UART, arbiter and memory responder side.
    modport slave (
        output rx_valid, rx_data, tx_ready, bus_gnt, mem_ready, mem_rdata,
        input  rx_ready, tx_valid, tx_data, bus_req, mem_valid,
               mem_addr, mem_wdata, mem_wstrb, busy
    );

endinterface

// File: rtl/dbg_bridge_timeout.sv
// Saturating elapsed-cycle counter: start loads 1 (the start cycle counts),
// en advances it, hit flags that LIMIT cycles have elapsed.
module dbg_bridge_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic hit
);

    localparam int             W       = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0]   LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= W'(1);
        end else if (en && (cnt != LIMIT_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == LIMIT_V);

endmodule

// File: rtl/dbg_bus_bridge.sv
// Debug command parser that turns UART byte commands into single-word
// transactions on the shared memory bus and streams back ACK/data/ERR bytes.
module dbg_bus_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int BUS_TIMEOUT  = 1024,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    dbg_bus_bridge_if.master  bus
);

    state_t      state, state_nxt;

    logic        op_is_write;
    logic [1:0]  byte_cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        rsp_rd;
    logic [2:0]  rsp_idx;
    logic [2:0]  rsp_last;
    logic [7:0]  rsp_byte;

    logic        rx_open;
    logic        rx_fire;
    logic        last_byte;
    logic        bus_hit;
    logic        idle_hit;

    assign rx_open   = (state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA);
    assign rx_fire   = bus.rx_valid && rx_open;
    assign last_byte = (byte_cnt == 2'd3);

    assign bus.rx_ready  = rx_open;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_wstrb = op_is_write ? 4'hF : 4'h0;

    // Bus timer measures cycles spent with mem_valid high.
    dbg_bridge_timeout #(.LIMIT(BUS_TIMEOUT)) u_bus_timer (
        .clk   (clk),
        .rst   (rst),
        .start (state == ST_REQ && bus.bus_gnt),
        .en    (state == ST_BUS),
        .hit   (bus_hit)
    );

    // Idle timer measures the gap since the last accepted command byte.
    dbg_bridge_timeout #(.LIMIT(IDLE_TIMEOUT)) u_idle_timer (
        .clk   (clk),
        .rst   (rst),
        .start (rx_fire),
        .en    (state == ST_ADDR || state == ST_DATA),
        .hit   (idle_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign rsp_last = rsp_rd ? 3'd4 : 3'd0;

    always_comb begin
        case (rsp_idx)
            3'd0:    rsp_byte = rsp_err ? RSP_ERR : RSP_ACK;
            3'd1:    rsp_byte = rdata[31:24];
            3'd2:    rsp_byte = rdata[23:16];
            3'd3:    rsp_byte = rdata[15:8];
            default: rsp_byte = rdata[7:0];
        endcase
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus.bus_req   = 1'b0;
        bus.mem_valid = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_fire) begin
                    state_nxt = is_opcode(bus.rx_data) ? ST_ADDR : ST_RESP;
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    if (last_byte) begin
                        if (bus.rx_data[1:0] != 2'b00) begin
                            state_nxt = ST_RESP;
                        end else begin
                            state_nxt = op_is_write ? ST_DATA : ST_REQ;
                        end
                    end
                end else if (idle_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_fire) begin
                    if (last_byte) begin
                        state_nxt = ST_REQ;
                    end
                end else if (idle_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) begin
                    state_nxt = ST_BUS;
                end
            end
            ST_BUS: begin
                // Grant loss is deliberately ignored once the transaction is on the bus.
                bus.bus_req   = 1'b1;
                bus.mem_valid = 1'b1;
                if (bus.mem_ready || bus_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = rsp_byte;
                if (bus.tx_ready && (rsp_idx == rsp_last)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_is_write <= 1'b0;
            byte_cnt    <= 2'd0;
            addr        <= 32'h0;
            wdata       <= 32'h0;
            rdata       <= 32'h0;
            rsp_err     <= 1'b0;
            rsp_rd      <= 1'b0;
            rsp_idx     <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        op_is_write <= (bus.rx_data == OP_WRITE);
                        byte_cnt    <= 2'd0;
                        rsp_idx     <= 3'd0;
                        rsp_err     <= !is_opcode(bus.rx_data);
                        rsp_rd      <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        addr     <= {addr[23:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte && (bus.rx_data[1:0] != 2'b00)) begin
                            rsp_err <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        wdata    <= {wdata[23:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ST_BUS: begin
                    if (bus.mem_ready) begin
                        rdata  <= bus.mem_rdata;
                        rsp_rd <= !op_is_write;
                    end else if (bus_hit) begin
                        rsp_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.tx_ready && (rsp_idx != rsp_last)) begin
                        rsp_idx <= rsp_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// Directed bench for dbg_bus_bridge: write, read, error paths, timeouts,
// arbitration/backpressure and asynchronous reset.
module tb_dbg_bus_bridge;
    import dbg_bridge_pkg::*;

    localparam int BUS_TO  = 8;
    localparam int IDLE_TO = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dbg_bus_bridge_if bif ();

    dbg_bus_bridge #(
        .BUS_TIMEOUT  (BUS_TO),
        .IDLE_TIMEOUT (IDLE_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Free-running activity monitors; tests compare snapshots of these.
    int mv_cycles      = 0;
    int req_low_cycles = 0;
    int tx_cycles      = 0;

    always @(negedge clk) begin
        if (bif.mem_valid) mv_cycles = mv_cycles + 1;
        if (!bif.bus_req)  req_low_cycles = req_low_cycles + 1;
        if (bif.tx_valid)  tx_cycles = tx_cycles + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        while (!bif.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_ready_wait", 32'(bif.rx_ready), 32'd1);
        step();
        bif.rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        send_byte(op);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        if (op == OP_WRITE) begin
            send_byte(d[31:24]);
            send_byte(d[23:16]);
            send_byte(d[15:8]);
            send_byte(d[7:0]);
        end
    endtask

    task automatic wait_mem_valid(input string tag);
        int n = 0;
        while (!bif.mem_valid && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check(tag, 32'(bif.mem_valid), 32'd1);
    endtask

    task automatic mem_respond(input logic [31:0] d);
        bif.mem_ready = 1'b1;
        bif.mem_rdata = d;
        step();
        bif.mem_ready = 1'b0;
        bif.mem_rdata = 32'h0;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!bif.tx_valid && n < 200) begin
            step();
            n++;
        end
        check(tag, 32'(bif.tx_data), 32'(exp));
        bif.tx_ready = 1'b1;
        step();
        bif.tx_ready = 1'b0;
    endtask

    int mv_base;
    int req_base;
    int tx_base;

    initial begin
        rst           = 1'b1;
        bif.rx_valid  = 1'b0;
        bif.rx_data   = 8'h00;
        bif.tx_ready  = 1'b0;
        bif.bus_gnt   = 1'b0;
        bif.mem_ready = 1'b0;
        bif.mem_rdata = 32'h0;

        // Reset state
        repeat (2) step();
        check("rst_rx_ready",  32'(bif.rx_ready),  32'd1);
        check("rst_busy",      32'(bif.busy),      32'd0);
        check("rst_mem_valid", 32'(bif.mem_valid), 32'd0);
        check("rst_bus_req",   32'(bif.bus_req),   32'd0);
        check("rst_tx_valid",  32'(bif.tx_valid),  32'd0);
        check("rst_tx_data",   32'(bif.tx_data),   32'd0);
        check("rst_mem_addr",  bif.mem_addr,       32'd0);
        check("rst_mem_wdata", bif.mem_wdata,      32'd0);
        check("rst_mem_wstrb", 32'(bif.mem_wstrb), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Write with grant already high; ready in first BUS cycle
        bif.bus_gnt = 1'b1;
        mv_base = mv_cycles;
        send_cmd(OP_WRITE, 32'h8000_0010, 32'hDEAD_BEEF);
        check("wr_lat_req",  32'(bif.bus_req),   32'd1);
        check("wr_lat_mv0",  32'(bif.mem_valid), 32'd0);
        step();
        check("wr_lat_mv1",  32'(bif.mem_valid), 32'd1);
        check("wr_addr",     bif.mem_addr,       32'h8000_0010);
        check("wr_wdata",    bif.mem_wdata,      32'hDEAD_BEEF);
        check("wr_wstrb",    32'(bif.mem_wstrb), 32'hF);
        mem_respond(32'h0);
        check("wr_mv_drop",  32'(bif.mem_valid), 32'd0);
        check("wr_req_drop", 32'(bif.bus_req),   32'd0);
        recv_byte("wr_ack", RSP_ACK);
        check("wr_busy",     32'(bif.busy),      32'd0);
        check("wr_mv_count", 32'(mv_cycles - mv_base), 32'd1);

        // Read, responder answers on the fifth BUS cycle
        send_cmd(OP_READ, 32'h8000_0010, 32'h0);
        wait_mem_valid("rd_mv_wait");
        check("rd_addr",  bif.mem_addr,       32'h8000_0010);
        check("rd_wstrb", 32'(bif.mem_wstrb), 32'h0);
        repeat (4) step();
        check("rd_mv_hold", 32'(bif.mem_valid), 32'd1);
        mem_respond(32'h1234_5678);
        recv_byte("rd_ack", RSP_ACK);
        recv_byte("rd_b3",  8'h12);
        recv_byte("rd_b2",  8'h34);
        recv_byte("rd_b1",  8'h56);
        recv_byte("rd_b0",  8'h78);
        check("rd_busy", 32'(bif.busy), 32'd0);

        // Misaligned address: error without bus access
        mv_base = mv_cycles;
        send_cmd(OP_READ, 32'h8000_0012, 32'h0);
        recv_byte("mis_err", RSP_ERR);
        check("mis_no_mv", 32'(mv_cycles - mv_base), 32'd0);
        check("mis_busy",  32'(bif.busy), 32'd0);

        // Unknown opcode
        send_byte(8'h7F);
        recv_byte("badop_err", RSP_ERR);
        check("badop_busy", 32'(bif.busy), 32'd0);

        // Bus timeout: mem_ready never arrives
        mv_base = mv_cycles;
        send_cmd(OP_READ, 32'h8000_0020, 32'h0);
        recv_byte("to_err", RSP_ERR);
        check("to_mv_cycles", 32'(mv_cycles - mv_base), 32'(BUS_TO));
        check("to_busy",      32'(bif.busy),    32'd0);
        check("to_bus_req",   32'(bif.bus_req), 32'd0);

        // Grant withheld, then dropped mid-transaction, then tx backpressure
        bif.bus_gnt = 1'b0;
        send_cmd(OP_READ, 32'h0000_0100, 32'h0);
        mv_base  = mv_cycles;
        req_base = req_low_cycles;
        repeat (20) step();
        check("gnt_no_mv",   32'(mv_cycles - mv_base),       32'd0);
        check("gnt_req_held", 32'(req_low_cycles - req_base), 32'd0);
        bif.bus_gnt = 1'b1;
        wait_mem_valid("gnt_mv_wait");
        check("gnt_addr", bif.mem_addr, 32'h0000_0100);
        bif.bus_gnt = 1'b0;
        step();
        check("gnt_drop_mv", 32'(bif.mem_valid), 32'd1);
        mem_respond(32'hCAFE_F00D);
        bif.bus_gnt = 1'b1;
        recv_byte("bp_ack", RSP_ACK);
        check("bp_valid0", 32'(bif.tx_valid), 32'd1);
        check("bp_data0",  32'(bif.tx_data),  32'hCA);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_data_hold", 32'(bif.tx_data), 32'hCA);
        end
        recv_byte("bp_b3", 8'hCA);
        recv_byte("bp_b2", 8'hFE);
        recv_byte("bp_b1", 8'hF0);
        recv_byte("bp_b0", 8'h0D);

        // mem_ready outside BUS is ignored
        bif.mem_ready = 1'b1;
        step();
        bif.mem_ready = 1'b0;
        step();
        check("stray_ready_busy", 32'(bif.busy),     32'd0);
        check("stray_ready_tx",   32'(bif.tx_valid), 32'd0);

        // Idle timeout mid-address, then a clean read
        tx_base = tx_cycles;
        send_byte(OP_WRITE);
        send_byte(8'h80);
        repeat (10) step();
        check("idle_busy_before", 32'(bif.busy), 32'd1);
        repeat (IDLE_TO) step();
        check("idle_busy_after", 32'(bif.busy), 32'd0);
        check("idle_no_tx",      32'(tx_cycles - tx_base), 32'd0);
        send_cmd(OP_READ, 32'h0000_0040, 32'h0);
        wait_mem_valid("idle_mv_wait");
        check("idle_rd_addr",  bif.mem_addr,       32'h0000_0040);
        check("idle_rd_wstrb", 32'(bif.mem_wstrb), 32'h0);
        mem_respond(32'h0BAD_C0DE);
        recv_byte("idle_ack", RSP_ACK);
        recv_byte("idle_b3",  8'h0B);
        recv_byte("idle_b2",  8'hAD);
        recv_byte("idle_b1",  8'hC0);
        recv_byte("idle_b0",  8'hDE);

        // Asynchronous reset while on the bus
        send_cmd(OP_WRITE, 32'h0000_0200, 32'h55AA_55AA);
        wait_mem_valid("rst_mv_wait");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_mem_valid", 32'(bif.mem_valid), 32'd0);
        check("arst_bus_req",   32'(bif.bus_req),   32'd0);
        check("arst_busy",      32'(bif.busy),      32'd0);
        check("arst_mem_addr",  bif.mem_addr,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dbg_bus_bridge.md
Name: dbg_bus_bridge

Overview:
- Byte-stream-to-memory-bus initiator for hardware debug.
- Parses word read/write commands arriving from the UART receive path and issues transactions as a second initiator on the SoC valid/ready memory bus, where the CPU is the first.
- Returns acknowledge, data or error bytes to the UART transmit path.
- Used to peek/poke BRAM, SDRAM and IO registers without CPU involvement.

Parameters:
- BUS_TIMEOUT, 1024: max cycles from mem_valid assertion to mem_ready before aborting.
- IDLE_TIMEOUT, 100000: max cycles between command bytes before the parser silently resets.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  received byte strobe
- rx_data  in  8  received byte
- rx_ready  out  1  bridge accepts a byte this cycle
- tx_valid  out  1  response byte valid, held until tx_ready
- tx_data  out  8  response byte
- tx_ready  in  1  transmitter accepts tx_data
- bus_req  out  1  request ownership of the memory bus
- bus_gnt  in  1  ownership granted by the arbiter
- mem_valid  out  1  transaction valid
- mem_addr  out  32  byte address, word aligned
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF for write, 4'h0 for read
- mem_ready  in  1  responder completion, one-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ready
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0 except rx_ready=1.
  - Address, data and counter registers are cleared.
- Command format, all fields MSB first:
  - Byte 0 is the opcode: 0x01 WRITE, 0x02 READ.
  - Bytes 1-4 are the address.
  - For WRITE only, bytes 5-8 are the data.
- Response bytes:
  - ACK 0xA5.
  - ERR 0xEE.
  - READ success sends ACK followed by 4 data bytes, MSB first.
- Byte handshake: a byte is consumed on rx_valid && rx_ready. rx_ready=1 only in IDLE, ADDR and DATA; bytes arriving in other states are dropped.
- States:
  - IDLE
    - Opcode 0x01 or 0x02 → ADDR with byte counter=0.
    - Any other opcode → RESP with ERR.
  - ADDR: shift byte into the address register; after the 4th byte:
    - addr[1:0]!=0 → RESP ERR, with no bus access.
    - Otherwise WRITE → DATA; READ → REQ.
  - DATA: shift 4 bytes into wdata, then → REQ.
  - REQ: bus_req=1. When bus_gnt=1, go to BUS on the next cycle.
  - BUS:
    - bus_req=1 and mem_valid=1; mem_addr, mem_wdata and mem_wstrb stay stable.
    - mem_ready → capture mem_rdata, drop mem_valid and bus_req in the same edge, → RESP ACK.
    - Timeout counter reaches BUS_TIMEOUT → drop mem_valid and bus_req, → RESP ERR.
  - RESP: present each byte with tx_valid until tx_ready; after the last byte → IDLE.
- Timing:
  - Latency from the last command byte to mem_valid is 2 cycles when bus_gnt is already high.
  - mem_ready in the first BUS cycle is legal.
- bus_gnt deasserted during BUS is ignored: the transaction completes.
- Idle timeout:
  - In ADDR or DATA, an inter-byte gap ≥ IDLE_TIMEOUT cycles → IDLE without a response.
  - Partial fields are discarded.
  - The counter restarts on every accepted byte.
- Timeout counters saturate and never wrap.
- Reset mid-transaction: mem_valid, bus_req and tx_valid drop asynchronously.
- mem_ready outside BUS is ignored.

Decomposition:
- Package dbg_bridge_pkg holds:
  - opcode constants OP_WRITE=8'h01, OP_READ=8'h02;
  - response constants RSP_ACK=8'hA5, RSP_ERR=8'hEE;
  - the state encoding.
- One sub-module dbg_bridge_timeout: loadable saturating counter with a compare-equal flag, instantiated twice (bus timeout and idle timeout).

Test Plan:
- Write: send 01 80 00 00 10 DE AD BE EF with bus_gnt=1 → one mem_valid with addr 0x80000010, wdata 0xDEADBEEF, wstrb F; after mem_ready, tx sends A5.
- Read: send 02 80 00 00 10, responder returns 0x12345678 after 5 cycles → wstrb 0, tx sends A5 12 34 56 78.
- Misaligned/bad opcode: send 02 80 00 00 12 → tx EE, mem_valid never asserts; send 7F → tx EE.
- Bus timeout (BUS_TIMEOUT=8): mem_ready never asserts → mem_valid high exactly 8 cycles, then tx EE, busy=0.
- Grant/backpressure: bus_gnt held low 20 cycles → mem_valid stays 0 and bus_req stays 1 throughout; tx_ready low 3 cycles during the response → tx_data stable, no bytes lost.
- Idle timeout/reset: send 01 80 then stall beyond IDLE_TIMEOUT → back to IDLE, next 02 ... executes a read correctly; assert rst in BUS → mem_valid=0 immediately.
